div_mult_unit: RTL and testbench
================================

DIV_MULT_UNIT -- requirements
Module: div_mult_unit

Interface
REQ-001 The block SHALL use one clock, `clk`; reset is `reset_in`, synchronous and active-high.
REQ-002 Port `clk`, input, 1 bit: rising-edge clock for all state.
REQ-003 Port `reset_in`, input, 1 bit: synchronous, active-high reset.
REQ-004 Port `start`, input, 1 bit: operation request, sampled at the rising edge.
REQ-005 Port `Div_Mult_Ctrl`, input, 1 bit: operation select, sampled with `start`; 0 = MULT, 1 = DIV.
REQ-006 Port `A`, input, 32 bits: multiplicand / dividend, signed two's complement, sampled with `start`.
REQ-007 Port `B`, input, 32 bits: multiplier / divisor, signed two's complement, sampled with `start`.
REQ-008 Port `HI`, output, 32 bits: MULT upper product word; DIV remainder.
REQ-009 Port `LO`, output, 32 bits: MULT lower product word; DIV quotient.
REQ-010 Port `busy`, output, 1 bit: high while an operation is in progress.
REQ-011 Port `done`, output, 1 bit: one-cycle completion pulse.
REQ-012 Port `DIV0`, output, 1 bit: one-cycle divide-by-zero exception pulse.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, CALC, FINISH.
REQ-014 In IDLE, `start`=1 at edge E0 SHALL capture `A`, `B` and `Div_Mult_Ctrl` and move to CALC, except for the divide-by-zero case in REQ-021.
REQ-015 CALC SHALL perform exactly 32 iterations, one per edge, at E1..E32.
- MULT: radix-2 Booth on signed operands, 64-bit product.
- DIV: restoring division on operand magnitudes.
REQ-016 After the 32nd iteration the FSM SHALL enter FINISH.
- At edge E33: HI/LO registered, `done`=1 for the following cycle only, FSM returns to IDLE.
REQ-017 `busy` SHALL be 1 for the cycles following E0..E32, and 0 during the `done` cycle.
REQ-018 MULT result SHALL be the full signed 64-bit product: HI = bits 63:32, LO = bits 31:0, no overflow flag.
REQ-019 DIV signs SHALL follow truncation toward zero.
- Quotient is negated when the operand signs differ.
- Remainder takes the sign of the dividend.
REQ-020 DIV 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0x00000000, with no exception.
REQ-021 DIV with `B`=0 sampled at E0 SHALL raise the exception instead of running.
- FSM stays in IDLE.
- `DIV0`=1 and `done`=1 for exactly the cycle after E0.
- HI/LO unchanged; `busy` stays 0.
REQ-022 `start` while `busy`=1 SHALL be ignored, including any change to the operands.
REQ-023 `start` during the `done` cycle SHALL be accepted, because the FSM is already in IDLE.
REQ-024 HI/LO SHALL hold their value between operations and change only at the FINISH edge.
REQ-025 Intermediate accumulators SHALL NOT be visible on HI/LO during CALC.

Reset
REQ-026 `reset_in`=1 at any edge SHALL set: state IDLE, HI=0, LO=0, `busy`=0, `done`=0, `DIV0`=0, iteration counter 0.
REQ-027 Reset SHALL take priority over `start` sampled at the same edge.
REQ-028 Reset during CALC SHALL abort the operation with no `done` pulse.
REQ-029 The first `start` after reset deasserts SHALL behave per REQ-014.

Verification
REQ-030 MULT A=7, B=0xFFFFFFFD (-3), start at E0 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB at E33; `done` high one cycle; `busy` high 33 cycles.
REQ-031 MULT A=B=0x80000000 -> HI=0x40000000, LO=0x00000000.
REQ-032 DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); second case A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-033 Prior result HI=0x11, LO=0x22, then DIV B=0 -> `DIV0`=1 and `done`=1 one cycle after start, `busy`=0 throughout, HI/LO remain 0x11/0x22.
REQ-034 MULT started, second `start` (DIV) at E5, `reset_in` at E10 -> second start ignored; all outputs 0 at E10; no `done`; a new MULT 3×4 afterwards -> LO=12, HI=0.
REQ-035 Back-to-back: new `start` asserted in the `done` cycle -> accepted; its result appears 33 edges later.

Source files
------------

// File: rtl/div_mult_unit.sv
// Sequential 32-bit signed multiply (radix-2 Booth) / divide (restoring, on magnitudes).
// One iteration per clock; results are published to HI/LO only on the FINISH edge.
module div_mult_unit (
   input  logic        clk,
   input  logic        reset_in,
   input  logic        start,
   input  logic        Div_Mult_Ctrl,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic        busy,
   output logic        done,
   output logic        DIV0
);

   // state    | meaning
   // S_IDLE   | waiting for start; also the cycle carrying done/DIV0
   // S_CALC   | 32 Booth or restoring iterations, one per edge
   // S_FINISH | sign fix-up and publish result to HI/LO
   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FINISH} state_t;

   state_t      r_state, w_next;
   logic [4:0]  r_cnt;
   logic        r_is_div, r_neg_q, r_neg_r, r_qm1;
   logic [31:0] r_m, r_lo, r_res_hi, r_res_lo;
   logic [32:0] r_hi;
   logic        r_done, r_div0;
   logic        w_accept, w_div_zero;
   logic [32:0] w_m_ext, w_booth, w_shift, w_trial;
   logic [31:0] w_abs_a, w_abs_b;

   assign w_div_zero = start && Div_Mult_Ctrl && (B == 32'd0);
   assign w_abs_a    = A[31] ? (32'd0 - A) : A;
   assign w_abs_b    = B[31] ? (32'd0 - B) : B;

   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start && !w_div_zero) begin
               w_accept = 1'b1;
               w_next   = S_CALC;
            end
         end
         S_CALC:   if (r_cnt == 5'd0) w_next = S_FINISH;
         S_FINISH: w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset_in) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   // 33-bit upper accumulator keeps Booth add/sub exact for -2^31 operands
   always_comb begin
      w_m_ext = {r_m[31], r_m};
      case ({r_lo[0], r_qm1})
         2'b01:   w_booth = r_hi + w_m_ext;
         2'b10:   w_booth = r_hi - w_m_ext;
         default: w_booth = r_hi;
      endcase
      w_shift = {r_hi[31:0], r_lo[31]};
      w_trial = w_shift - {1'b0, r_m};
   end

   always_ff @(posedge clk) begin
      if (reset_in) begin
         r_cnt    <= 5'd0;
         r_is_div <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_qm1    <= 1'b0;
         r_m      <= 32'd0;
         r_hi     <= 33'd0;
         r_lo     <= 32'd0;
         r_res_hi <= 32'd0;
         r_res_lo <= 32'd0;
         r_done   <= 1'b0;
         r_div0   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_div0 <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_div_zero) begin
                  r_done <= 1'b1;
                  r_div0 <= 1'b1;
               end else if (w_accept) begin
                  r_is_div <= Div_Mult_Ctrl;
                  r_hi     <= 33'd0;
                  r_qm1    <= 1'b0;
                  r_cnt    <= 5'd31;
                  if (Div_Mult_Ctrl) begin
                     r_m     <= w_abs_b;
                     r_lo    <= w_abs_a;
                     r_neg_q <= A[31] ^ B[31];
                     r_neg_r <= A[31];
                  end else begin
                     r_m     <= A;
                     r_lo    <= B;
                     r_neg_q <= 1'b0;
                     r_neg_r <= 1'b0;
                  end
               end
            end
            S_CALC: begin
               if (r_cnt != 5'd0) r_cnt <= r_cnt - 5'd1;
               if (r_is_div) begin
                  if (!w_trial[32]) begin
                     r_hi <= w_trial;
                     r_lo <= {r_lo[30:0], 1'b1};
                  end else begin
                     r_hi <= w_shift;
                     r_lo <= {r_lo[30:0], 1'b0};
                  end
               end else begin
                  r_hi  <= {w_booth[32], w_booth[32:1]};
                  r_lo  <= {w_booth[0], r_lo[31:1]};
                  r_qm1 <= r_lo[0];
               end
            end
            S_FINISH: begin
               r_done <= 1'b1;
               if (r_is_div) begin
                  r_res_lo <= r_neg_q ? (32'd0 - r_lo) : r_lo;
                  r_res_hi <= r_neg_r ? (32'd0 - r_hi[31:0]) : r_hi[31:0];
               end else begin
                  r_res_hi <= r_hi[31:0];
                  r_res_lo <= r_lo;
               end
            end
            default: ;
         endcase
      end
   end

   assign HI   = r_res_hi;
   assign LO   = r_res_lo;
   assign busy = (r_state != S_IDLE);
   assign done = r_done;
   assign DIV0 = r_div0;

endmodule

// File: tb/tb_div_mult_unit.sv
// Bench for div_mult_unit: cycle-level reference model compared every cycle,
// directed literal cases, then randomized start/reset traffic.
module tb_div_mult_unit;

   logic        clk = 1'b0;
   logic        reset_in, start, Div_Mult_Ctrl;
   logic [31:0] A, B, HI, LO;
   logic        busy, done, DIV0;

   always #5 clk = ~clk;

   div_mult_unit dut (
      .clk(clk), .reset_in(reset_in), .start(start), .Div_Mult_Ctrl(Div_Mult_Ctrl),
      .A(A), .B(B), .HI(HI), .LO(LO), .busy(busy), .done(done), .DIV0(DIV0)
   );

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference arithmetic: plain 64-bit signed math, truncating division.
   function automatic logic [63:0] ref_op(input logic ctrl, input logic [31:0] a, input logic [31:0] b);
      longint x, y, q, r;
      x = longint'($signed(a));
      y = longint'($signed(b));
      if (!ctrl) return x * y;
      q = x / y;
      r = x % y;
      return {r[31:0], q[31:0]};
   endfunction

   // Model: an accepted op yields its result 33 edges after the start edge.
   logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
   bit          m_busy = 0, m_done = 0, m_div0 = 0;
   int          m_left = 0;

   always @(posedge clk) begin
      if (reset_in) begin
         m_hi = 0; m_lo = 0; m_busy = 0; m_done = 0; m_div0 = 0; m_left = 0;
      end else begin
         m_done = 0;
         m_div0 = 0;
         if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
               m_hi = p_hi; m_lo = p_lo; m_done = 1; m_busy = 0;
            end
         end else if (start) begin
            if (Div_Mult_Ctrl && B == 32'd0) begin
               m_done = 1; m_div0 = 1;
            end else begin
               {p_hi, p_lo} = ref_op(Div_Mult_Ctrl, A, B);
               m_left = 33;
               m_busy = 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("busy", busy, m_busy);
         check("done", done, m_done);
         check("DIV0", DIV0, m_div0);
         check("HI", HI, m_hi);
         check("LO", LO, m_lo);
      end
   end

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'd0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'h7FFF_FFFF;
         4: return 32'($urandom_range(0, 15));
         5: return 32'd0 - 32'($urandom_range(1, 15));
         default: return $urandom;
      endcase
   endfunction

   // Called at a negedge; returns at the negedge where done is seen (or bound expires).
   task automatic run_op(input logic ctrl, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int bcnt);
      start = 1'b1; Div_Mult_Ctrl = ctrl; A = a; B = b;
      @(negedge clk);
      start = 1'b0; A = $urandom; B = $urandom;
      lat  = 0;
      bcnt = int'(busy);
      while (!done && lat < 40) begin
         @(negedge clk);
         lat++;
         if (busy) bcnt++;
      end
   endtask

   initial begin
      int lat, bcnt, d;
      reset_in = 1'b1; start = 1'b0; Div_Mult_Ctrl = 1'b0; A = 32'd0; B = 32'd0;
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      check("rst_HI", HI, 32'd0);
      check("rst_LO", LO, 32'd0);
      check("rst_busy", busy, 1'b0);
      reset_in = 1'b0;

      run_op(1'b0, 32'd7, 32'hFFFF_FFFD, lat, bcnt);
      check("mul7x-3_lat", lat, 33);
      check("mul7x-3_busy_cycles", bcnt, 33);
      check("mul7x-3_HI", HI, 32'hFFFF_FFFF);
      check("mul7x-3_LO", LO, 32'hFFFF_FFEB);
      @(negedge clk);
      check("done_one_cycle", done, 1'b0);

      run_op(1'b0, 32'h8000_0000, 32'h8000_0000, lat, bcnt);
      check("mulmin_HI", HI, 32'h4000_0000);
      check("mulmin_LO", LO, 32'h0000_0000);

      run_op(1'b1, 32'hFFFF_FFF9, 32'd2, lat, bcnt);
      check("div-7/2_LO", LO, 32'hFFFF_FFFD);
      check("div-7/2_HI", HI, 32'hFFFF_FFFF);

      run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt);
      check("divmin_LO", LO, 32'h8000_0000);
      check("divmin_HI", HI, 32'h0000_0000);
      check("divmin_DIV0", DIV0, 1'b0);

      run_op(1'b1, 32'h0000_0451, 32'h0000_0020, lat, bcnt);
      check("div_prior_HI", HI, 32'h11);
      check("div_prior_LO", LO, 32'h22);

      @(negedge clk);
      start = 1'b1; Div_Mult_Ctrl = 1'b1; A = 32'd5; B = 32'd0;
      @(negedge clk);
      start = 1'b0;
      check("div0_DIV0", DIV0, 1'b1);
      check("div0_done", done, 1'b1);
      check("div0_busy", busy, 1'b0);
      check("div0_HI", HI, 32'h11);
      check("div0_LO", LO, 32'h22);
      @(negedge clk);
      check("div0_DIV0_clear", DIV0, 1'b0);
      check("div0_busy_after", busy, 1'b0);

      // Start at E0, ignored start at E5, reset at E10.
      start = 1'b1; Div_Mult_Ctrl = 1'b0; A = 32'd5; B = 32'd6;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      start = 1'b1; Div_Mult_Ctrl = 1'b1; A = 32'd100; B = 32'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      reset_in = 1'b1;
      @(negedge clk);
      reset_in = 1'b0;
      check("abort_HI", HI, 32'd0);
      check("abort_LO", LO, 32'd0);
      check("abort_busy", busy, 1'b0);
      check("abort_done", done, 1'b0);
      d = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) d++;
      end
      check("abort_no_done", d, 0);

      run_op(1'b0, 32'd3, 32'd4, lat, bcnt);
      check("mul3x4_LO", LO, 32'd12);
      check("mul3x4_HI", HI, 32'd0);

      // Issued in the done cycle of the previous op.
      run_op(1'b1, 32'hFFFF_FF9C, 32'd7, lat, bcnt);
      check("b2b_lat", lat, 33);
      check("b2b_LO", LO, 32'hFFFF_FFF2);
      check("b2b_HI", HI, 32'hFFFF_FFFE);

      for (int i = 0; i < 3000; i++) begin
         reset_in      = ($urandom_range(0, 299) == 0);
         start         = ($urandom_range(0, 3) == 0);
         Div_Mult_Ctrl = 1'($urandom_range(0, 1));
         A             = pick();
         B             = pick();
         @(negedge clk);
      end
      reset_in = 1'b0;
      start    = 1'b0;
      repeat (40) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
